// File: rtl/a25_wb_pkg.sv
// a25_wb_pkg: shared definitions for the A25 Wishbone master.
//   wb_state_t        - master FSM states (IDLE, BEAT, DONE)
//   P_ICACHE/P_DCACHE/P_UNCACHED - requesting buffer indices
//   WB_WORDS          - 32-bit words per 128-bit request line
package a25_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    localparam logic [1:0] P_ICACHE   = 2'd0;
    localparam logic [1:0] P_DCACHE   = 2'd1;
    localparam logic [1:0] P_UNCACHED = 2'd2;

    localparam int unsigned WB_WORDS = 4;

endpackage

// File: rtl/a25_wb_beat_mask.sv
// a25_wb_beat_mask: decides which words of a 128-bit request become bus beats
// and walks them in ascending order.
//   write, be, addr_word, port - request being accepted
//   mask, first_word           - beat mask and first word for that request
//   cur_mask, cur_word         - latched mask and word of the beat in flight
//   next_word, has_next        - next included word above cur_word, if any
module a25_wb_beat_mask
    import a25_wb_pkg::*;
(
    input  logic        write,
    input  logic [15:0] be,
    input  logic [1:0]  addr_word,
    input  logic [1:0]  port,
    input  logic [3:0]  cur_mask,
    input  logic [1:0]  cur_word,
    output logic [3:0]  mask,
    output logic [1:0]  first_word,
    output logic [1:0]  next_word,
    output logic        has_next
);

    always_comb begin
        mask = '0;
        if (write) begin
            for (int unsigned k = 0; k < WB_WORDS; k++) begin
                mask[k] = |be[4*k +: 4];
            end
        end else if (port == P_UNCACHED) begin
            mask[addr_word] = 1'b1;
        end else begin
            mask = '1;
        end
    end

    // Descending scans so the lowest qualifying word is the one left standing.
    always_comb begin
        first_word = '0;
        for (int unsigned k = WB_WORDS; k > 0; k--) begin
            if (mask[k-1]) first_word = 2'(k - 1);
        end
    end

    always_comb begin
        next_word = '0;
        has_next  = 1'b0;
        for (int unsigned k = WB_WORDS; k > 0; k--) begin
            if (cur_mask[k-1] && ((k - 1) > 32'(cur_word))) begin
                next_word = 2'(k - 1);
                has_next  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/a25_wishbone_master.sv
// a25_wishbone_master: arbitrates the three A25 Wishbone buffers (p0 icache,
// p1 cached dcache, p2 uncached dcache; fixed priority p2 > p1 > p0) and turns
// each 128-bit request into Wishbone classic single-word cycles on a 32-bit bus.
// Read beats are assembled into a line returned with a one-cycle rdata_valid.
//   i_clk, i_rst                  - clock, async active-high reset
//   i_pN_* / o_pN_*               - per-port request, accept and read return
//   o_wb_* / i_wb_*               - Wishbone master bus
//   o_bus_error                   - sticky, set by err (or timeout), reset only
// Optional: define A25_WB_TIMEOUT_EN to abort a beat after TIMEOUT_CYCLES
// cycles without ack/err (treated as err).
module a25_wishbone_master
    import a25_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_p0_valid,
    output logic         o_p0_accepted,
    input  logic         i_p0_write,
    input  logic [127:0] i_p0_wdata,
    input  logic [15:0]  i_p0_be,
    input  logic [31:0]  i_p0_addr,
    output logic [127:0] o_p0_rdata,
    output logic         o_p0_rdata_valid,
    input  logic         i_p1_valid,
    output logic         o_p1_accepted,
    input  logic         i_p1_write,
    input  logic [127:0] i_p1_wdata,
    input  logic [15:0]  i_p1_be,
    input  logic [31:0]  i_p1_addr,
    output logic [127:0] o_p1_rdata,
    output logic         o_p1_rdata_valid,
    input  logic         i_p2_valid,
    output logic         o_p2_accepted,
    input  logic         i_p2_write,
    input  logic [127:0] i_p2_wdata,
    input  logic [15:0]  i_p2_be,
    input  logic [31:0]  i_p2_addr,
    output logic [127:0] o_p2_rdata,
    output logic         o_p2_rdata_valid,
    output logic [31:0]  o_wb_adr,
    output logic [3:0]   o_wb_sel,
    output logic         o_wb_we,
    output logic [31:0]  o_wb_dat,
    input  logic [31:0]  i_wb_dat,
    output logic         o_wb_cyc,
    output logic         o_wb_stb,
    input  logic         i_wb_ack,
    input  logic         i_wb_err,
    output logic         o_bus_error
);

    wb_state_t    state;
    logic [1:0]   port_q;
    logic         write_q;
    logic [127:0] wdata_q;
    logic [15:0]  be_q;
    logic [31:4]  addr_q;
    logic [3:0]   mask_q;
    logic [1:0]   word_q;
    logic [127:0] line_q;
    logic [127:0] rdata0_q, rdata1_q, rdata2_q;
    logic         bus_error_q;

    logic         win_valid;
    logic [1:0]   win_port;
    logic         win_write;
    logic [127:0] win_wdata;
    logic [15:0]  win_be;
    logic [31:0]  win_addr;
    logic         take;

    logic [3:0]   mask;
    logic [1:0]   first_word, next_word;
    logic         has_next;
    logic         beat_timeout, beat_end, beat_bad, rd_done;

    always_comb begin
        win_valid = i_p0_valid | i_p1_valid | i_p2_valid;
        win_port  = P_ICACHE;
        win_write = i_p0_write;
        win_wdata = i_p0_wdata;
        win_be    = i_p0_be;
        win_addr  = i_p0_addr;
        if (i_p2_valid) begin
            win_port  = P_UNCACHED;
            win_write = i_p2_write;
            win_wdata = i_p2_wdata;
            win_be    = i_p2_be;
            win_addr  = i_p2_addr;
        end else if (i_p1_valid) begin
            win_port  = P_DCACHE;
            win_write = i_p1_write;
            win_wdata = i_p1_wdata;
            win_be    = i_p1_be;
            win_addr  = i_p1_addr;
        end
    end

    // Byte offset within a word is meaningless on a word-addressed bus.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^win_addr[1:0];

    assign take = (state == IDLE) && win_valid && !i_rst;
    assign o_p0_accepted = take && (win_port == P_ICACHE);
    assign o_p1_accepted = take && (win_port == P_DCACHE);
    assign o_p2_accepted = take && (win_port == P_UNCACHED);

    a25_wb_beat_mask u_beat_mask (
        .write      (win_write),
        .be         (win_be),
        .addr_word  (win_addr[3:2]),
        .port       (win_port),
        .cur_mask   (mask_q),
        .cur_word   (word_q),
        .mask       (mask),
        .first_word (first_word),
        .next_word  (next_word),
        .has_next   (has_next)
    );

    assign beat_end = (state == BEAT) && (i_wb_ack || i_wb_err || beat_timeout);
    assign beat_bad = i_wb_err || beat_timeout;

`ifdef A25_WB_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside BEAT and on every beat boundary, so each beat starts from 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if ((state != BEAT) || beat_end) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign beat_timeout = (state == BEAT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign beat_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            port_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            word_q      <= '0;
            line_q      <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        port_q  <= win_port;
                        write_q <= win_write;
                        wdata_q <= win_wdata;
                        be_q    <= win_be;
                        addr_q  <= win_addr[31:4];
                        mask_q  <= mask;
                        word_q  <= first_word;
                        line_q  <= '0;
                        state   <= (mask == '0) ? DONE : BEAT;
                    end
                end
                BEAT: begin
                    if (beat_end) begin
                        if (!write_q) line_q[{word_q, 5'd0} +: 32] <= beat_bad ? '0 : i_wb_dat;
                        if (beat_bad) bus_error_q <= 1'b1;
                        if (has_next) word_q <= next_word;
                        else          state  <= DONE;
                    end
                end
                DONE: begin
                    if (!write_q) begin
                        if (port_q == P_ICACHE) rdata0_q <= line_q;
                        if (port_q == P_DCACHE) rdata1_q <= line_q;
                        if (port_q == P_UNCACHED) rdata2_q <= line_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_wb_cyc = (state == BEAT);
    assign o_wb_stb = (state == BEAT);
    assign o_wb_adr = {addr_q, word_q, 2'b00};
    assign o_wb_sel = be_q[{word_q, 2'b00} +: 4];
    assign o_wb_dat = wdata_q[{word_q, 5'd0} +: 32];
    assign o_wb_we  = write_q;
    assign o_bus_error = bus_error_q;

    // The line is shown directly during the pulse; the per-port copy is
    // updated in the same cycle so it holds the value afterwards.
    assign rd_done = (state == DONE) && !write_q;
    assign o_p0_rdata_valid = rd_done && (port_q == P_ICACHE);
    assign o_p1_rdata_valid = rd_done && (port_q == P_DCACHE);
    assign o_p2_rdata_valid = rd_done && (port_q == P_UNCACHED);
    assign o_p0_rdata = o_p0_rdata_valid ? line_q : rdata0_q;
    assign o_p1_rdata = o_p1_rdata_valid ? line_q : rdata1_q;
    assign o_p2_rdata = o_p2_rdata_valid ? line_q : rdata2_q;

endmodule

// File: tb/tb_a25_wishbone_master.sv
// tb_a25_wishbone_master: self-checking bench for a25_wishbone_master.
// A transaction-level model predicts accepts, beats, read lines and the
// sticky error flag; a bench-side slave answers beats with wait states/errors.
module tb_a25_wishbone_master;

    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]   valid, write, acc, rv;
    logic [127:0] wdata [3];
    logic [15:0]  be    [3];
    logic [31:0]  addr  [3];
    logic [127:0] rdata [3];
    logic [31:0]  wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]   wb_sel;
    logic         wb_we, wb_cyc, wb_stb, wb_ack, wb_err, bus_error;

    a25_wishbone_master #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_valid(valid[0]), .o_p0_accepted(acc[0]), .i_p0_write(write[0]),
        .i_p0_wdata(wdata[0]), .i_p0_be(be[0]), .i_p0_addr(addr[0]),
        .o_p0_rdata(rdata[0]), .o_p0_rdata_valid(rv[0]),
        .i_p1_valid(valid[1]), .o_p1_accepted(acc[1]), .i_p1_write(write[1]),
        .i_p1_wdata(wdata[1]), .i_p1_be(be[1]), .i_p1_addr(addr[1]),
        .o_p1_rdata(rdata[1]), .o_p1_rdata_valid(rv[1]),
        .i_p2_valid(valid[2]), .o_p2_accepted(acc[2]), .i_p2_write(write[2]),
        .i_p2_wdata(wdata[2]), .i_p2_be(be[2]), .i_p2_addr(addr[2]),
        .o_p2_rdata(rdata[2]), .o_p2_rdata_valid(rv[2]),
        .o_wb_adr(wb_adr), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_dat(wb_dat_o),
        .i_wb_dat(wb_dat_i), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_bus_error(bus_error)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        int           port;
        bit           wr;
        logic [31:0]  a;
        logic [15:0]  b;
        logic [127:0] wd;
        int           nb;
        logic [31:0]  first;
        logic [31:0]  last;
        bit           rvx;
        logic [127:0] line;
    } vec_t;

    int n_cmp = 0, n_bad = 0;

    // model state
    beat_t        exp_q[$];
    int           acc_order[$];
    int           cur_port;
    bit           cur_write, done_cycle, exp_err;
    logic [127:0] mline;
    bit [2:0]     acc_seen;
    // staged requests, driven at the start of the next cycle
    bit           stg_v [3];
    bit           stg_w [3];
    logic [127:0] stg_wd [3];
    logic [15:0]  stg_be [3];
    logic [31:0]  stg_a [3];
    // slave behaviour
    int           wait_min, wait_max, wait_left, beat_cyc, beat_idx, err_beat, err_pct;
    bit           never_ack;
    logic [31:0]  salt;
    int           rnd_left;
    // per-transaction record of what the DUT showed
    int           txn_done, t_nbeats;
    logic [31:0]  t_first, t_last;
    bit           t_rv;
    logic [127:0] t_rdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sdata(input logic [31:0] a);
        return 32'hD000_0000 ^ a ^ salt;
    endfunction

    function automatic int new_wait();
        return $urandom_range(wait_max, wait_min);
    endfunction

    task automatic start_txn(input int p);
        logic [3:0] nib;
        bit inc;
        beat_t b;
        cur_port = p; cur_write = write[p]; mline = '0;
        t_nbeats = 0; t_rv = 0; t_first = '0; t_last = '0;
        beat_idx = 0; beat_cyc = 0; wait_left = new_wait();
        for (int k = 0; k < 4; k++) begin
            nib = be[p][4*k +: 4];
            if (write[p])   inc = (nib != 4'h0);
            else if (p == 2) inc = (addr[p][3:2] == 2'(k));
            else            inc = 1'b1;
            if (inc) begin
                b.adr = {addr[p][31:4], 2'(k), 2'b00};
                b.sel = nib;
                b.we  = write[p];
                b.dat = wdata[p][32*k +: 32];
                exp_q.push_back(b);
            end
        end
        if (exp_q.size() == 0) done_cycle = 1'b1;
    endtask

    task automatic sample();
        logic [2:0] exp_acc, exp_rv;
        bit idle, fin, bad;
        int k;
        idle = (exp_q.size() == 0) && !done_cycle;
        exp_acc = '0;
        if (idle) begin
            if (valid[2])      exp_acc = 3'b100;
            else if (valid[1]) exp_acc = 3'b010;
            else if (valid[0]) exp_acc = 3'b001;
        end
        chk("accepted", acc, exp_acc);
        exp_rv = '0;
        if (done_cycle && !cur_write) exp_rv[cur_port] = 1'b1;
        chk("rdata_valid", rv, exp_rv);
        if (exp_rv != 0) begin
            chk("rdata", rdata[cur_port], mline);
            t_rv = 1'b1;
            t_rdata = rdata[cur_port];
        end
        chk("bus_error", bus_error, exp_err);
        chk("cyc_stb", {wb_cyc, wb_stb}, (exp_q.size() > 0) ? 2'b11 : 2'b00);

        if (done_cycle) begin
            done_cycle = 1'b0;
            txn_done++;
        end else if (exp_q.size() > 0) begin
            chk("wb_adr", wb_adr, exp_q[0].adr);
            chk("wb_sel", wb_sel, exp_q[0].sel);
            chk("wb_we", wb_we, exp_q[0].we);
            if (exp_q[0].we) chk("wb_dat", wb_dat_o, exp_q[0].dat);
            fin = 1'b0; bad = 1'b0;
            if (never_ack) begin
                if (beat_cyc == TO - 1) begin fin = 1'b1; bad = 1'b1; end
                else beat_cyc++;
            end else if (wait_left > 0) begin
                wait_left--;
            end else begin
                fin = 1'b1;
                bad = (beat_idx == err_beat) || ($urandom_range(99, 0) < err_pct);
                wb_dat_i = sdata(exp_q[0].adr);
                if (bad) begin wb_err = 1'b1; wb_ack = 1'($urandom_range(1, 0)); end
                else wb_ack = 1'b1;
            end
            if (fin) begin
                k = int'(exp_q[0].adr[3:2]);
                if (!cur_write) mline[32*k +: 32] = bad ? 32'h0 : sdata(exp_q[0].adr);
                if (bad) exp_err = 1'b1;
                t_nbeats++;
                if (t_nbeats == 1) t_first = wb_adr;
                t_last = wb_adr;
                void'(exp_q.pop_front());
                beat_idx++; beat_cyc = 0; wait_left = new_wait();
                if (exp_q.size() == 0) done_cycle = 1'b1;
            end
        end

        for (int p = 0; p < 3; p++) begin
            if (exp_acc[p]) begin
                acc_seen[p] = 1'b1;
                acc_order.push_back(p);
                start_txn(p);
            end
        end
    endtask

    task automatic apply();
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom;
        for (int p = 0; p < 3; p++) begin
            if (acc_seen[p]) begin valid[p] = 1'b0; acc_seen[p] = 1'b0; end
            if (stg_v[p]) begin
                write[p] = stg_w[p]; wdata[p] = stg_wd[p]; be[p] = stg_be[p]; addr[p] = stg_a[p];
                valid[p] = 1'b1; stg_v[p] = 1'b0;
            end
            if (rnd_left > 0 && !valid[p] && $urandom_range(3, 0) == 0) begin
                rnd_left--;
                write[p] = 1'($urandom_range(1, 0));
                addr[p]  = $urandom;
                wdata[p] = {$urandom, $urandom, $urandom, $urandom};
                be[p]    = 16'hffff;
                if (write[p]) begin
                    for (int k = 0; k < 4; k++) begin
                        case ($urandom_range(2, 0))
                            0: be[p][4*k +: 4] = 4'h0;
                            1: be[p][4*k +: 4] = 4'hf;
                            default: be[p][4*k +: 4] = 4'($urandom);
                        endcase
                    end
                end
                valid[p] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        apply();
        #1;
        sample();
    endtask

    task automatic stage(input int p, input bit w, input logic [31:0] a,
                         input logic [15:0] b, input logic [127:0] wd);
        stg_v[p] = 1'b1; stg_w[p] = w; stg_a[p] = a; stg_be[p] = b; stg_wd[p] = wd;
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (txn_done < target && n < budget) begin
            cycle();
            n++;
        end
        if (txn_done < target) chk({name, "_budget"}, 0, 1);
    endtask

    vec_t vt [8];

    initial begin
        rst = 1'b1;
        valid = 3'b111; write = '0; wb_ack = 0; wb_err = 0; wb_dat_i = '0;
        for (int p = 0; p < 3; p++) begin
            wdata[p] = '0; be[p] = 16'hffff; addr[p] = 32'h100 * (p + 1);
            stg_v[p] = 0; stg_w[p] = 0; stg_wd[p] = '0; stg_be[p] = '0; stg_a[p] = '0;
        end
        cur_port = 0; cur_write = 0; done_cycle = 0; exp_err = 0; mline = '0; acc_seen = '0;
        wait_min = 1; wait_max = 1; wait_left = 0; beat_cyc = 0; beat_idx = 0;
        err_beat = -1; err_pct = 0; never_ack = 0; salt = '0; rnd_left = 0;
        txn_done = 0; t_nbeats = 0; t_first = '0; t_last = '0; t_rv = 0; t_rdata = '0;

        // reset state, with all requests pending
        repeat (2) @(posedge clk);
        #1;
        chk("rst_accepted", acc, 3'b000);
        chk("rst_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
        chk("rst_rdata_valid", rv, 3'b000);
        chk("rst_bus_error", bus_error, 1'b0);
        chk("rst_bus_out", {wb_adr, wb_sel, wb_we, wb_dat_o}, '0);
        chk("rst_rdata0", rdata[0], '0);
        valid = '0;
        rst = 1'b0;

        vt[0] = '{0, 1'b0, 32'h100, 16'hffff, 128'h0, 4, 32'h100, 32'h10C, 1'b1,
                  {32'hD000010C, 32'hD0000108, 32'hD0000104, 32'hD0000100}};
        vt[1] = '{2, 1'b1, 32'h20, 16'h00f0, {64'h0, 32'hDEADBEEF, 32'h0}, 1, 32'h24, 32'h24, 1'b0, 128'h0};
        vt[2] = '{2, 1'b0, 32'h38, 16'hffff, 128'h0, 1, 32'h38, 32'h38, 1'b1, {32'h0, 32'hD0000038, 64'h0}};
        vt[3] = '{1, 1'b1, 32'h40, 16'hf00f, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2, 32'h40, 32'h4C, 1'b0, 128'h0};
        vt[4] = '{1, 1'b1, 32'h50, 16'h0000, {4{32'h5555_5555}}, 0, 32'h0, 32'h0, 1'b0, 128'h0};
        vt[5] = '{1, 1'b0, 32'h1F4, 16'hffff, 128'h0, 4, 32'h1F0, 32'h1FC, 1'b1,
                  {32'hD00001FC, 32'hD00001F8, 32'hD00001F4, 32'hD00001F0}};
        vt[6] = '{2, 1'b0, 32'h204, 16'hffff, 128'h0, 1, 32'h204, 32'h204, 1'b1, {64'h0, 32'hD0000204, 32'h0}};
        vt[7] = '{0, 1'b1, 32'h64, 16'h0f00, {32'h0, 32'h12345678, 64'h0}, 1, 32'h68, 32'h68, 1'b0, 128'h0};

        // directed table: one wait state per beat
        for (int i = 0; i < 8; i++) begin
            stage(vt[i].port, vt[i].wr, vt[i].a, vt[i].b, vt[i].wd);
            run_until(txn_done + 1, 100, "vec");
            chk($sformatf("vec%0d_nbeats", i), t_nbeats, vt[i].nb);
            if (vt[i].nb > 0) begin
                chk($sformatf("vec%0d_first_adr", i), t_first, vt[i].first);
                chk($sformatf("vec%0d_last_adr", i), t_last, vt[i].last);
            end
            chk($sformatf("vec%0d_rdata_valid", i), t_rv, vt[i].rvx);
            if (vt[i].rvx) chk($sformatf("vec%0d_line", i), t_rdata, vt[i].line);
        end

        // simultaneous requests: served p2, p1, p0
        wait_min = 0; wait_max = 0;
        stage(0, 1'b0, 32'h500, 16'hffff, '0);
        stage(1, 1'b0, 32'h600, 16'hffff, '0);
        stage(2, 1'b0, 32'h700, 16'hffff, '0);
        run_until(txn_done + 3, 100, "prio");
        chk("prio_first", acc_order[acc_order.size() - 3], 2);
        chk("prio_second", acc_order[acc_order.size() - 2], 1);
        chk("prio_third", acc_order[acc_order.size() - 1], 0);

        // err on the third beat (word 2) of a p1 read
        err_beat = 2;
        stage(1, 1'b0, 32'h300, 16'hffff, '0);
        run_until(txn_done + 1, 100, "err");
        err_beat = -1;
        chk("err_nbeats", t_nbeats, 4);
        chk("err_word2", t_rdata[95:64], 32'h0);
        chk("err_word3", t_rdata[127:96], sdata(32'h30C));
        stage(0, 1'b0, 32'h340, 16'hffff, '0);
        run_until(txn_done + 1, 100, "err_sticky");
        chk("err_sticky", bus_error, 1'b1);

`ifdef A25_WB_TIMEOUT_EN
        never_ack = 1'b1;
        stage(2, 1'b0, 32'h38, 16'hffff, '0);
        run_until(txn_done + 1, 100, "timeout");
        never_ack = 1'b0;
        chk("timeout_nbeats", t_nbeats, 1);
        chk("timeout_line", t_rdata, 128'h0);
        chk("timeout_bus_error", bus_error, 1'b1);
`endif

        // reset during a beat: bus drops at once, request is lost
        wait_min = 50; wait_max = 50;
        stage(0, 1'b0, 32'h400, 16'hffff, '0);
        repeat (4) cycle();
        valid[1] = 1'b1; addr[1] = 32'h800; write[1] = 1'b0; be[1] = 16'hffff;
        rst = 1'b1;
        #1;
        chk("midrst_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
        chk("midrst_rdata_valid", rv, 3'b000);
        chk("midrst_accepted", acc, 3'b000);
        chk("midrst_bus_error", bus_error, 1'b0);
        exp_q.delete(); done_cycle = 1'b0; exp_err = 1'b0; valid = '0; acc_seen = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) cycle();

        // randomized traffic against the model
        salt = $urandom; wait_min = 0; wait_max = 2; err_pct = 5;
        rnd_left = 60;
        run_until(txn_done + 60, 5000, "random");
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/a25_wishbone_master.md
Name: a25_wishbone_master

Overview:
- Downstream neighbour of the three per-port Wishbone buffers: icache reads, cached dcache, uncached dcache.
- Arbitrates the buffer requests and converts each 128-bit request into Wishbone classic single-word cycles on a 32-bit bus.
- Read beats are collected into a 128-bit line, which is returned to the requesting buffer as a one-cycle i_rdata_valid pulse.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles to wait for ack/err on one beat (used only when A25_WB_TIMEOUT_EN is defined).

Ports:
- i_clk  in  1  clock; all logic rising-edge
- i_rst  in  1  asynchronous active-high reset
- i_pN_valid  in  1  port N request (N=0 icache, 1 cached dcache, 2 uncached dcache)
- o_pN_accepted  out  1  request taken this cycle
- i_pN_write  in  1  write request when 1
- i_pN_wdata  in  128  write data; word k = bits 32k+31:32k
- i_pN_be  in  16  byte enables (16'hffff on reads)
- i_pN_addr  in  32  byte address
- o_pN_rdata  out  128  read line
- o_pN_rdata_valid  out  1  one-cycle read completion pulse
- o_wb_adr  out  32  word address, bits 1:0 = 0
- o_wb_sel  out  4  byte selects
- o_wb_we  out  1  write enable
- o_wb_dat  out  32  write data
- i_wb_dat  in  32  read data
- o_wb_cyc  out  1  cycle
- o_wb_stb  out  1  strobe
- i_wb_ack  in  1  beat acknowledge
- i_wb_err  in  1  beat error
- o_bus_error  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset:
  - All registered outputs 0; state IDLE.
  - o_pN_accepted forced 0 while i_rst is high.
- States:
  - IDLE: no cycle on the bus; selects a winner.
  - BEAT: cyc=stb=1; wait for ack/err.
  - DONE: cyc=stb=0 for exactly one cycle; read completion pulsed here.
- Arbitration (IDLE only):
  - Fixed priority p2 > p1 > p0.
  - o_pN_accepted = (state==IDLE) && winner==N, combinational, same cycle as valid.
  - Accept latches write, wdata, be, addr and port index; next state BEAT.
  - Losing ports keep valid high and are not accepted.
- Beat mask, computed at accept:
  - Writes: word k is included iff be[4k+3:4k] != 0. A mask of 0 goes straight to DONE with no bus cycle.
  - Reads on p0/p1: all 4 words.
  - Reads on p2: only word addr[3:2].
- Beat sequencing:
  - Words are issued in ascending k, skipping excluded words.
  - o_wb_adr = {addr[31:4], k[1:0], 2'b00}.
  - o_wb_sel = be nibble k; o_wb_dat = wdata word k; o_wb_we = write.
- Handshake:
  - Bus outputs are held stable while cyc&&stb&&!ack&&!err.
  - On ack: read data is captured into word k of the line register, then move to the next word, or to DONE after the last.
  - On err: same as ack, except the captured word is 32'h0 and o_bus_error is set.
  - ack and err asserted together are treated as err.
  - Back-to-back beats of one request keep cyc high; stb stays high and the address updates in the cycle after ack.
- DONE:
  - On reads, o_pN_rdata_valid pulses for the owning port, with o_pN_rdata = line register.
  - Words not fetched in a p2 read return 0.
  - Writes produce no rdata_valid.
  - DONE → IDLE. Earliest next accept is one cycle after DONE, so the minimum gap between requests is 1 idle cycle.
- o_pN_rdata holds its last value between pulses.
- Reset mid-operation: cyc/stb drop immediately (async); the request is lost; the buffer is not acknowledged.

Optional Feature:
- Macro: A25_WB_TIMEOUT_EN.
- Defined:
  - An 8+ bit per-beat counter is cleared on entry to each beat.
  - If it reaches TIMEOUT_CYCLES-1 with no ack/err, the beat is treated as err: data 0, o_bus_error set, sequencing advances.
- Undefined:
  - No counter; a beat waits forever.
  - o_bus_error is set only by i_wb_err.

Decomposition:
- Package a25_wb_pkg:
  - state enum IDLE/BEAT/DONE;
  - port index constants P_ICACHE=0, P_DCACHE=1, P_UNCACHED=2;
  - WB_WORDS=4.
- One sub-module a25_wb_beat_mask: combinational.
  - Inputs: write, be, addr[3:2], port index.
  - Outputs: 4-bit beat mask and first/next-word selection.

Test Plan:
- p0 read at addr 32'h100, slave acks each beat after 1 wait state:
  - adr sequence 100,104,108,10C; sel=4'hf; we=0;
  - rdata_valid one pulse; line = {d3,d2,d1,d0}.
- p2 write at addr 32'h20, be=16'h00f0, wdata word1=32'hdeadbeef:
  - single beat, adr 32'h24, sel 4'hf, dat deadbeef, we=1;
  - no rdata_valid.
- p0, p1 and p2 valid simultaneously:
  - p2 accepted first, then p1, then p0;
  - each accept follows the previous DONE plus the idle cycle.
- p2 read at addr 32'h38:
  - one beat at 32'h38; rdata = {32'h0, data, 64'h0};
  - word 2 holds the data.
- i_wb_err on beat 2 of a p1 read:
  - word 2 = 0; o_bus_error=1 until reset; remaining beats complete.
- A25_WB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave never acks:
  - beat aborted after 16 cycles; o_bus_error=1.
- i_rst asserted during a BEAT:
  - cyc/stb/rdata_valid go to 0 the same cycle.
